cam_stream_uart: RTL and testbench
==================================

Name: cam_stream_uart

Overview:
- Parametrised successor to the camera-to-UART luminance path. Captures OV7670 YUV 4:2:2 bytes on PCLK rising edges and selects bytes by run-time mode.
- Optional steps: decimate in x/y, threshold to binary.
- Buffers selected bytes in a FIFO and streams them out of an internal 8N1 UART transmitter.
- Sits between the camera pins and the host serial link. Replaces the unbuffered, Y-only, 12 Mbaud path.

Parameters:
- BAUD_DIV, 1: clk cycles per UART bit (1 = 12 Mbaud at 12 MHz).
- FIFO_AW, 4: FIFO address width; depth = 2**FIFO_AW.
- DECIM_X, 1: keep one of every DECIM_X selected bytes per line (1..255).
- DECIM_Y, 1: keep one of every DECIM_Y lines per frame (1..255).
- THRESH, 128: binary-mode threshold.

Ports:
- clk  in  1  system clock; must be at least 4x PCLK.
- rst_hw_n  in  1  synchronous active-low reset.
- PCLK  in  1  camera pixel clock (asynchronous).
- Href  in  1  line valid.
- VSYNC  in  1  frame sync; high = blanking.
- in_pixel  in  8  camera data.
- mode  in  2  00 even bytes, 01 odd bytes, 10 all bytes, 11 even bytes thresholded.
- tx  out  1  UART serial output.
- busy  out  1  transmitter active or FIFO non-empty.
- fifo_level  out  FIFO_AW+1  current FIFO occupancy.
- ovf_cnt  out  8  dropped-byte counter, saturating.

Behaviour:
- Reset (rst_hw_n low at posedge clk):
  - tx=1, busy=0, fifo_level=0, ovf_cnt=0.
  - FIFO empty; all counters 0; UART state IDLE.
  - Applying reset mid-frame aborts any byte in flight: tx returns to 1 the next cycle.
- Input sync:
  - PCLK, Href, VSYNC and in_pixel each pass through 2 flops.
  - A PCLK rise is detected when the synced PCLK is 1 and the previous synced sample was 0; call this cycle E.
  - The sample is qualified only if synced Href=1 and VSYNC=0 at E.
- Byte parity:
  - A parity toggle clears while Href=0 or VSYNC=1.
  - The first byte of each line is even (index 0).
- Selection by mode:
  - 00: even bytes.
  - 01: odd bytes.
  - 10: every byte.
  - 11: even bytes, output 0xFF if value >= THRESH, else 0x00.
  - mode is sampled at each E; mid-line changes take effect on the next qualified byte.
- X decimation:
  - Counter xcnt increments per selected byte and wraps at DECIM_X-1.
  - A byte is kept when xcnt==0.
  - xcnt clears at line start (Href rising).
- Y decimation:
  - Counter ycnt increments on Href falling edge and wraps at DECIM_Y-1.
  - ycnt clears on VSYNC=1.
  - Lines with ycnt!=0 are discarded entirely.
- Enqueue:
  - A kept byte is written at E+1.
  - If the FIFO is full at E+1, the byte is dropped and ovf_cnt increments, saturating at 255. ovf_cnt clears only on reset.
- FIFO:
  - Synchronous, first-word fall-through not required.
  - A simultaneous push and pop when full is allowed and does not count as overflow; the pop frees a slot in the same cycle.
  - Level is unchanged on simultaneous push and pop.
- UART FSM (states IDLE, START, DATA, STOP):
  - IDLE: if FIFO non-empty, pop, latch the byte, go to START next cycle with tx=0.
  - Each state holds BAUD_DIV cycles.
  - DATA sends 8 bits LSB first; STOP drives tx=1 for BAUD_DIV cycles, then IDLE.
  - Back-to-back bytes have no extra idle cycles: the pop happens in the last STOP cycle.
  - Frame time = 10*BAUD_DIV cycles per byte.
- busy = (state!=IDLE) | (fifo_level!=0).

Optional Feature:
- Macro: CAM_FRAME_MARK_EN.
- Defined:
  - On each synced VSYNC falling edge (frame start), byte 0x00 is enqueued before any pixel data of that frame. Overflow rules apply if the FIFO is full.
  - All pixel bytes are clamped: 0x00 becomes 0x01, so 0x00 is unique to the frame start. Mode 11 emits 0x01/0xFF.
- Undefined: no marker, no clamping; the path is purely pixel data.

Test Plan:
- Reset: hold rst_hw_n=0 for 3 cycles mid-transmission -> tx=1, fifo_level=0, ovf_cnt=0 on the next cycle; no further start bits.
- Mode 00, BAUD_DIV=1: line bytes 0x10,0x80,0x20,0x81 -> tx frames 0x10 then 0x20, LSB first, 10 cycles each, back-to-back.
- Mode 11, THRESH=128: even bytes 0x7F,0x80 -> serial 0x00 then 0xFF. Mode 10 on 4 bytes -> 4 frames in order.
- DECIM_X=2, DECIM_Y=2, mode 00: 2 lines of 8 bytes -> line 0 yields bytes 0 and 4; line 1 yields nothing.
- Overflow: FIFO_AW=2, BAUD_DIV=16, mode 10, 12 bytes at PCLK = clk/4 -> fifo_level peaks at 4; ovf_cnt counts exactly the dropped bytes; 300 forced drops saturate at 255.
- CAM_FRAME_MARK_EN: VSYNC 1->0, then even byte 0x00 -> serial 0x00 then 0x01. Without the macro -> serial 0x00 only.

Source files
------------

// File: rtl/cam_stream_uart.sv
// cam_stream_uart
//   Captures OV7670 YUV 4:2:2 bytes on camera PCLK rising edges, selects
//   bytes by run-time mode, optionally decimates in x/y and thresholds to
//   binary, buffers the result in a FIFO and sends it out an 8N1 UART.
//
// Ports
//   clk         system clock, at least 4x PCLK
//   rst_hw_n    synchronous active-low reset
//   PCLK        camera pixel clock (asynchronous to clk)
//   Href        line valid
//   VSYNC       frame sync, high during blanking
//   in_pixel    camera data byte
//   mode        00 even bytes, 01 odd bytes, 10 all bytes,
//               11 even bytes thresholded to 0x00/0xFF
//   tx          UART serial output, idles high
//   busy        transmitter active or FIFO non-empty
//   fifo_level  current FIFO occupancy
//   ovf_cnt     saturating count of bytes dropped on a full FIFO
//
// Optional build macro
//   CAM_FRAME_MARK_EN  enqueue a 0x00 marker at each frame start and clamp
//                      pixel bytes so 0x00 never appears as pixel data.

module cam_stream_uart #(
  parameter int BAUD_DIV = 1,
  parameter int FIFO_AW  = 4,
  parameter int DECIM_X  = 1,
  parameter int DECIM_Y  = 1,
  parameter int THRESH   = 128
) (
  input  logic             clk,
  input  logic             rst_hw_n,
  input  logic             PCLK,
  input  logic             Href,
  input  logic             VSYNC,
  input  logic [7:0]       in_pixel,
  input  logic [1:0]       mode,
  output logic             tx,
  output logic             busy,
  output logic [FIFO_AW:0] fifo_level,
  output logic [7:0]       ovf_cnt
);

  localparam int               DEPTH     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LVL  = DEPTH[FIFO_AW:0];
  localparam logic [7:0]       XLAST     = 8'(DECIM_X - 1);
  localparam logic [7:0]       YLAST     = 8'(DECIM_Y - 1);
  localparam logic [15:0]      BAUD_LAST = 16'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // ---------------------------------------------------------------- input sync
  logic [1:0] pclk_sync, href_sync, vsync_sync;
  logic [7:0] pix_meta, pix_s;
  logic       pclk_d, href_d;
  logic       pclk_s, href_s, vsync_s;

  // NOTE: every clocked register uses non-blocking assignments so all flops
  // sample their inputs from before the edge; blocking here would collapse
  // the two-flop synchronisers into one.
  always_ff @(posedge clk) begin
    if (!rst_hw_n) begin
      pclk_sync  <= '0;
      href_sync  <= '0;
      vsync_sync <= '0;
      pix_meta   <= '0;
      pix_s      <= '0;
      pclk_d     <= 1'b0;
      href_d     <= 1'b0;
    end else begin
      pclk_sync  <= {pclk_sync[0], PCLK};
      href_sync  <= {href_sync[0], Href};
      vsync_sync <= {vsync_sync[0], VSYNC};
      pix_meta   <= in_pixel;
      pix_s      <= pix_meta;
      pclk_d     <= pclk_s;
      href_d     <= href_s;
    end
  end

  assign pclk_s  = pclk_sync[1];
  assign href_s  = href_sync[1];
  assign vsync_s = vsync_sync[1];

  logic pclk_rise, qual, line_start, line_end;
  assign pclk_rise  = pclk_s & ~pclk_d;
  assign qual       = pclk_rise & href_s & ~vsync_s;
  assign line_start = href_s & ~href_d;
  assign line_end   = ~href_s & href_d;

  // ------------------------------------------------------- selection / decim
  logic       odd_byte;
  logic       sel;
  logic       sel_byte, keep;
  logic [7:0] xcnt, xcur, ycnt;
  logic [7:0] pix_val, pix_out;

  // NOTE: combinational blocks assign every output a default first so no
  // path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    sel     = 1'b0;
    pix_val = pix_s;
    case (mode)
      2'b00:   sel = ~odd_byte;
      2'b01:   sel = odd_byte;
      2'b10:   sel = 1'b1;
      default: begin
        sel     = ~odd_byte;
        pix_val = (int'(pix_s) >= THRESH) ? 8'hFF : 8'h00;
      end
    endcase
  end

  assign sel_byte = qual & sel;
  // A line start coinciding with a sample must see the cleared counter.
  assign xcur     = line_start ? 8'd0 : xcnt;
  assign keep     = sel_byte & (xcur == 8'd0) & (ycnt == 8'd0);

  always_ff @(posedge clk) begin
    if (!rst_hw_n) begin
      odd_byte <= 1'b0;
      xcnt     <= '0;
      ycnt     <= '0;
    end else begin
      if (!href_s || vsync_s) odd_byte <= 1'b0;
      else if (qual)          odd_byte <= ~odd_byte;

      if (sel_byte) xcnt <= (xcur == XLAST) ? 8'd0 : xcur + 8'd1;
      else          xcnt <= xcur;

      if (vsync_s)       ycnt <= '0;
      else if (line_end) ycnt <= (ycnt == YLAST) ? 8'd0 : ycnt + 8'd1;
    end
  end

  // --------------------------------------------------------- enqueue stage
  logic       stg_vld;
  logic [7:0] stg_data;

`ifdef CAM_FRAME_MARK_EN
  logic       vsync_d, frame_start;
  logic       hold_vld;
  logic [7:0] hold_data;

  assign frame_start = ~vsync_s & vsync_d;
  // 0x00 is reserved for the frame marker.
  assign pix_out     = (pix_val == 8'h00) ? 8'h01 : pix_val;

  // A pixel kept in the frame-start cycle waits one cycle behind the marker;
  // the 4x clock ratio guarantees the next sample is further away.
  always_ff @(posedge clk) begin
    if (!rst_hw_n) begin
      vsync_d   <= 1'b0;
      stg_vld   <= 1'b0;
      stg_data  <= '0;
      hold_vld  <= 1'b0;
      hold_data <= '0;
    end else begin
      vsync_d <= vsync_s;
      if (frame_start) begin
        stg_vld   <= 1'b1;
        stg_data  <= 8'h00;
        hold_vld  <= keep;
        hold_data <= pix_out;
      end else if (hold_vld) begin
        stg_vld  <= 1'b1;
        stg_data <= hold_data;
        hold_vld <= 1'b0;
      end else begin
        stg_vld  <= keep;
        stg_data <= pix_out;
      end
    end
  end
`else
  assign pix_out = pix_val;

  always_ff @(posedge clk) begin
    if (!rst_hw_n) begin
      stg_vld  <= 1'b0;
      stg_data <= '0;
    end else begin
      stg_vld  <= keep;
      stg_data <= pix_out;
    end
  end
`endif

  // ------------------------------------------------------------------ FIFO
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic               full, empty, push, pop;

  assign full  = (fifo_level == FULL_LVL);
  assign empty = (fifo_level == '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push  = stg_vld & (~full | pop);

  // NOTE: the storage array has no reset; only pointers and level define
  // which entries are valid, so clearing the data would be wasted logic.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= stg_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_hw_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      ovf_cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (stg_vld && !push && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
    end
  end

  // ------------------------------------------------------------------ UART
  state_t      state, state_nx;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        baud_done;

  assign baud_done = (baud_cnt == BAUD_LAST);

  // The pop in the last STOP cycle lets the next start bit follow directly.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    tx       = 1'b1;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          state_nx = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (baud_done) state_nx = DATA;
      end
      DATA: begin
        tx = shreg[0];
        if (baud_done && bit_idx == 3'd7) state_nx = STOP;
      end
      default: begin
        if (baud_done) begin
          if (!empty) begin
            pop      = 1'b1;
            state_nx = START;
          end else begin
            state_nx = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_hw_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE || baud_done) baud_cnt <= '0;
      else                            baud_cnt <= baud_cnt + 16'd1;
      if (state == DATA && baud_done) bit_idx <= bit_idx + 3'd1;
      if (pop)                             shreg <= mem[rd_ptr];
      else if (state == DATA && baud_done) shreg <= {1'b0, shreg[7:1]};
    end
  end

  assign busy = (state != IDLE) | ~empty;

endmodule

// File: tb/tb_cam_stream_uart.sv
module tb_cam_stream_uart;

`ifdef CAM_FRAME_MARK_EN
  localparam bit MARK = 1'b1;
`else
  localparam bit MARK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_hw_n = 1'b0;
  logic       PCLK = 1'b0;
  logic       Href = 1'b0;
  logic       VSYNC = 1'b0;
  logic [7:0] in_pixel = 8'h00;
  logic [1:0] mode = 2'b00;

  logic       tx0, tx1, tx2, busy0, busy1, busy2;
  logic [4:0] lvl0, lvl1;
  logic [2:0] lvl2;
  logic [7:0] ovf0, ovf1, ovf2;
  logic [2:0] tx_v;

  assign tx_v = {tx2, tx1, tx0};

  // u0: defaults, u1: x/y decimation, u2: small slow FIFO for overflow
  cam_stream_uart u0 (
    .clk(clk), .rst_hw_n(rst_hw_n), .PCLK(PCLK), .Href(Href), .VSYNC(VSYNC),
    .in_pixel(in_pixel), .mode(mode), .tx(tx0), .busy(busy0),
    .fifo_level(lvl0), .ovf_cnt(ovf0));

  cam_stream_uart #(.DECIM_X(2), .DECIM_Y(2)) u1 (
    .clk(clk), .rst_hw_n(rst_hw_n), .PCLK(PCLK), .Href(Href), .VSYNC(VSYNC),
    .in_pixel(in_pixel), .mode(mode), .tx(tx1), .busy(busy1),
    .fifo_level(lvl1), .ovf_cnt(ovf1));

  cam_stream_uart #(.FIFO_AW(2), .BAUD_DIV(16)) u2 (
    .clk(clk), .rst_hw_n(rst_hw_n), .PCLK(PCLK), .Href(Href), .VSYNC(VSYNC),
    .in_pixel(in_pixel), .mode(mode), .tx(tx2), .busy(busy2),
    .fifo_level(lvl2), .ovf_cnt(ovf2));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------- UART receivers
  logic [7:0] rx_buf [3][1024];
  int         rx_t   [3][1024];
  int         rx_n   [3];
  int         rx_ferr[3];
  bit         rx_act [3];
  int         rx_cnt [3];
  int         rx_st  [3];
  logic [7:0] rx_sh  [3];
  int         peak2;

  initial begin
    for (int k = 0; k < 3; k++) begin
      rx_n[k] = 0; rx_ferr[k] = 0; rx_act[k] = 1'b0; rx_cnt[k] = 0;
      rx_st[k] = 0; rx_sh[k] = 8'h00;
    end
    peak2 = 0;
  end

  always @(negedge clk) begin
    if (!rst_hw_n) peak2 = 0;
    else if (int'(lvl2) > peak2) peak2 = int'(lvl2);
    for (int k = 0; k < 3; k++) begin
      int bd;
      int bn;
      bd = (k == 2) ? 16 : 1;
      if (!rst_hw_n) begin
        rx_act[k] = 1'b0;
      end else if (!rx_act[k]) begin
        if (tx_v[k] == 1'b0) begin
          rx_act[k] = 1'b1; rx_cnt[k] = 0; rx_st[k] = cyc;
        end
      end else begin
        rx_cnt[k]++;
        if (rx_cnt[k] % bd == 0) begin
          bn = rx_cnt[k] / bd;
          if (bn <= 8) begin
            rx_sh[k] = {tx_v[k], rx_sh[k][7:1]};
          end else begin
            if (tx_v[k] !== 1'b1) rx_ferr[k]++;
            if (rx_n[k] < 1024) begin
              rx_buf[k][rx_n[k]] = rx_sh[k];
              rx_t[k][rx_n[k]]   = rx_st[k];
            end
            rx_n[k]++;
            rx_act[k] = 1'b0;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------- camera driver
  logic [7:0] line_buf [512];

  task automatic cam_line(input int n, input int half);
    Href = 1'b1;
    repeat (half) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      in_pixel = line_buf[i];
      PCLK = 1'b0;
      repeat (half) @(negedge clk);
      PCLK = 1'b1;
      repeat (half) @(negedge clk);
    end
    PCLK = 1'b0;
    Href = 1'b0;
    repeat (4 * half + 4) @(negedge clk);
  endtask

  task automatic reset_all();
    PCLK = 1'b0; Href = 1'b0; VSYNC = 1'b0; in_pixel = 8'h00;
    rst_hw_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_hw_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_rx(input int k, input int n, input int limit);
    int c;
    c = 0;
    while (rx_n[k] < n && c < limit) begin
      @(negedge clk);
      c++;
    end
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    int lows;
    int base;
    reset_all();
    mode = 2'b10;
    for (int i = 0; i < 6; i++) line_buf[i] = 8'hA1 + 8'(i);
    cam_line(6, 2);
    checks++;
    if (busy2 !== 1'b1) begin errors++; $display("FAIL pre_reset_busy: got %0b want 1", busy2); end
    checks++;
    if (ovf2 !== 8'd1) begin errors++; $display("FAIL pre_reset_ovf: got %0d want 1", ovf2); end
    rst_hw_n = 1'b0;
    @(negedge clk);
    checks++;
    if (tx2 !== 1'b1) begin errors++; $display("FAIL reset_tx: got %0b want 1", tx2); end
    checks++;
    if (lvl2 !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", lvl2); end
    checks++;
    if (ovf2 !== 8'd0) begin errors++; $display("FAIL reset_ovf: got %0d want 0", ovf2); end
    checks++;
    if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy2); end
    checks++;
    if (tx0 !== 1'b1 || lvl0 !== 5'd0 || busy0 !== 1'b0) begin
      errors++; $display("FAIL reset_u0: got tx=%0b lvl=%0d busy=%0b want 1 0 0", tx0, lvl0, busy0);
    end
    repeat (2) @(negedge clk);
    rst_hw_n = 1'b1;
    base = rx_n[2];
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx_v !== 3'b111) lows++;
    end
    checks++;
    if (lows != 0 || rx_n[2] != base) begin
      errors++; $display("FAIL reset_no_start: got %0d low cycles want 0", lows);
    end
  endtask

  task automatic test_mode00();
    int base;
    reset_all();
    mode = 2'b00;
    base = rx_n[0];
    line_buf[0] = 8'h10; line_buf[1] = 8'h80; line_buf[2] = 8'h20; line_buf[3] = 8'h81;
    cam_line(4, 2);
    wait_rx(0, base + 2, 300);
    repeat (30) @(negedge clk);
    checks++;
    if (rx_n[0] - base != 2) begin
      errors++; $display("FAIL m00_count: got %0d want 2", rx_n[0] - base);
    end else begin
      checks++;
      if (rx_buf[0][base] !== 8'h10) begin errors++; $display("FAIL m00_byte0: got %h want 10", rx_buf[0][base]); end
      checks++;
      if (rx_buf[0][base+1] !== 8'h20) begin errors++; $display("FAIL m00_byte1: got %h want 20", rx_buf[0][base+1]); end
      checks++;
      if (rx_t[0][base+1] - rx_t[0][base] != 10) begin
        errors++; $display("FAIL m00_b2b: got %0d cycles want 10", rx_t[0][base+1] - rx_t[0][base]);
      end
    end
    checks++;
    if (rx_ferr[0] != 0) begin errors++; $display("FAIL m00_stop_bit: got %0d framing errors want 0", rx_ferr[0]); end
  endtask

  task automatic test_mode11();
    int base;
    logic [7:0] e0;
    reset_all();
    mode = 2'b11;
    base = rx_n[0];
    e0 = MARK ? 8'h01 : 8'h00;
    line_buf[0] = 8'h7F; line_buf[1] = 8'h11; line_buf[2] = 8'h80; line_buf[3] = 8'h22;
    cam_line(4, 2);
    wait_rx(0, base + 2, 300);
    repeat (30) @(negedge clk);
    checks++;
    if (rx_n[0] - base != 2) begin
      errors++; $display("FAIL m11_count: got %0d want 2", rx_n[0] - base);
    end else begin
      checks++;
      if (rx_buf[0][base] !== e0) begin errors++; $display("FAIL m11_below: got %h want %h", rx_buf[0][base], e0); end
      checks++;
      if (rx_buf[0][base+1] !== 8'hFF) begin errors++; $display("FAIL m11_at_thresh: got %h want ff", rx_buf[0][base+1]); end
    end
  endtask

  task automatic test_mode10();
    int base;
    logic [7:0] exp_b [4];
    reset_all();
    mode = 2'b10;
    base = rx_n[0];
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
    for (int i = 0; i < 4; i++) line_buf[i] = exp_b[i];
    cam_line(4, 2);
    checks++;
    if (busy0 !== 1'b1) begin errors++; $display("FAIL m10_busy_active: got %0b want 1", busy0); end
    wait_rx(0, base + 4, 300);
    repeat (30) @(negedge clk);
    checks++;
    if (rx_n[0] - base != 4) begin
      errors++; $display("FAIL m10_count: got %0d want 4", rx_n[0] - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rx_buf[0][base+i] !== exp_b[i]) begin
          errors++; $display("FAIL m10_byte%0d: got %h want %h", i, rx_buf[0][base+i], exp_b[i]);
        end
      end
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (rx_t[0][base+i] - rx_t[0][base+i-1] != 10) begin
          errors++; $display("FAIL m10_b2b%0d: got %0d cycles want 10", i, rx_t[0][base+i] - rx_t[0][base+i-1]);
        end
      end
    end
    checks++;
    if (busy0 !== 1'b0) begin errors++; $display("FAIL m10_busy_idle: got %0b want 0", busy0); end
  endtask

  task automatic test_decim();
    int base;
    reset_all();
    mode = 2'b00;
    base = rx_n[1];
    for (int i = 0; i < 8; i++) line_buf[i] = 8'h41 + 8'(i);
    cam_line(8, 2);
    for (int i = 0; i < 8; i++) line_buf[i] = 8'h51 + 8'(i);
    cam_line(8, 2);
    wait_rx(1, base + 2, 300);
    repeat (60) @(negedge clk);
    checks++;
    if (rx_n[1] - base != 2) begin
      errors++; $display("FAIL decim_count: got %0d want 2", rx_n[1] - base);
    end else begin
      checks++;
      if (rx_buf[1][base] !== 8'h41) begin errors++; $display("FAIL decim_byte0: got %h want 41", rx_buf[1][base]); end
      checks++;
      if (rx_buf[1][base+1] !== 8'h45) begin errors++; $display("FAIL decim_byte1: got %h want 45", rx_buf[1][base+1]); end
    end
  endtask

  task automatic test_overflow();
    int base;
    reset_all();
    mode = 2'b10;
    base = rx_n[2];
    for (int i = 0; i < 12; i++) line_buf[i] = 8'h01 + 8'(i);
    cam_line(12, 2);
    checks++;
    if (peak2 != 4) begin errors++; $display("FAIL ovf_peak_level: got %0d want 4", peak2); end
    checks++;
    if (ovf2 !== 8'd7) begin errors++; $display("FAIL ovf_count: got %0d want 7", ovf2); end
    wait_rx(2, base + 5, 1200);
    repeat (200) @(negedge clk);
    checks++;
    if (rx_n[2] - base != 5) begin
      errors++; $display("FAIL ovf_rx_count: got %0d want 5", rx_n[2] - base);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (rx_buf[2][base+i] !== 8'h01 + 8'(i)) begin
          errors++; $display("FAIL ovf_rx_byte%0d: got %h want %h", i, rx_buf[2][base+i], 8'h01 + 8'(i));
        end
      end
    end
    checks++;
    if (lvl2 !== 3'd0) begin errors++; $display("FAIL ovf_drained: got %0d want 0", lvl2); end
    for (int i = 0; i < 300; i++) line_buf[i] = 8'(i) | 8'h01;
    cam_line(300, 2);
    checks++;
    if (ovf2 !== 8'd255) begin errors++; $display("FAIL ovf_saturate: got %0d want 255", ovf2); end
    cam_line(20, 2);
    checks++;
    if (ovf2 !== 8'd255) begin errors++; $display("FAIL ovf_hold: got %0d want 255", ovf2); end
  endtask

  task automatic test_frame_mark();
    int base;
    int want_n;
    reset_all();
    mode = 2'b00;
    base = rx_n[0];
    want_n = MARK ? 2 : 1;
    VSYNC = 1'b1;
    repeat (10) @(negedge clk);
    VSYNC = 1'b0;
    repeat (10) @(negedge clk);
    line_buf[0] = 8'h00; line_buf[1] = 8'h99;
    cam_line(2, 4);
    wait_rx(0, base + want_n, 300);
    repeat (40) @(negedge clk);
    checks++;
    if (rx_n[0] - base != want_n) begin
      errors++; $display("FAIL mark_count: got %0d want %0d", rx_n[0] - base, want_n);
    end else begin
      checks++;
      if (rx_buf[0][base] !== 8'h00) begin errors++; $display("FAIL mark_first: got %h want 00", rx_buf[0][base]); end
      if (MARK) begin
        checks++;
        if (rx_buf[0][base+1] !== 8'h01) begin errors++; $display("FAIL mark_clamp: got %h want 01", rx_buf[0][base+1]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode00();
    test_mode11();
    test_mode10();
    test_decim();
    test_overflow();
    test_frame_mark();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
